// File: rtl/sdram_burst_reader.sv
// sdram_burst_reader
//   Avalon-MM burst read master for the HPS f2h_sdram0 read-only port. It
//   fetches num_words contiguous 64-bit words starting at start_addr and
//   presents them as a ready/valid stream through a show-ahead FIFO. Reads
//   are only issued while the FIFO has room for every word already requested
//   plus the next burst, so the FIFO cannot overflow even if st_ready stays low.
//
// Ports
//   clk, reset          : single clock (also feeds the bridge clock), async active-high reset
//   start, start_addr,
//   num_words           : transfer request, sampled only while idle
//   busy, done          : transfer in progress / one-cycle completion pulse
//   avm_*               : Avalon-MM burst read master
//   st_data, st_valid,
//   st_ready            : output stream
//   checksum            : sum mod 2^64 of popped words (only with SDRAM_READER_CSUM_EN)
//
// Build option: define SDRAM_READER_CSUM_EN to add the checksum port and adder.

module sdram_burst_reader #(
  parameter int ADDR_W     = 29,
  parameter int DATA_W     = 64,
  parameter int BURST_W    = 8,
  parameter int MAX_BURST  = 16,
  parameter int FIFO_DEPTH = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W-1:0]  start_addr,
  input  logic [31:0]        num_words,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  avm_address,
  output logic [BURST_W-1:0] avm_burstcount,
  output logic               avm_read,
  input  logic               avm_waitrequest,
  input  logic [DATA_W-1:0]  avm_readdata,
  input  logic               avm_readdatavalid,
  output logic [DATA_W-1:0]  st_data,
  output logic               st_valid,
  input  logic               st_ready
`ifdef SDRAM_READER_CSUM_EN
  ,
  output logic [63:0]        checksum
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SUM_W = CNT_W + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       to_issue_reg;
  logic [31:0]       to_deliver_reg;
  logic [CNT_W-1:0]  outstanding_reg;
  logic [CNT_W-1:0]  fifo_count_reg;
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];

  logic [31:0]       len;
  logic [SUM_W-1:0]  credit_sum;
  logic              credit_ok;
  logic              accept;
  logic              push;
  logic              pop;
  logic              take_start;

  assign len        = (to_issue_reg < 32'(MAX_BURST)) ? to_issue_reg : 32'(MAX_BURST);
  // fifo_count + outstanding never exceeds FIFO_DEPTH and len <= FIFO_DEPTH/2,
  // so one extra bit is enough to hold the sum without wrapping.
  assign credit_sum = SUM_W'(fifo_count_reg) + SUM_W'(outstanding_reg) + SUM_W'(len);
  assign credit_ok  = credit_sum <= SUM_W'(FIFO_DEPTH);

  // Read is a pure function of registered state. While waitrequest stalls a
  // burst the credit sum can only shrink (a push trades outstanding for
  // fifo_count, a pop lowers it), so a raised read stays raised until accepted.
  assign avm_read       = (state_reg == ISSUE) && credit_ok;
  assign avm_address    = addr_reg;
  assign avm_burstcount = (state_reg == ISSUE) ? BURST_W'(len) : '0;
  assign accept         = avm_read && !avm_waitrequest;

  // Words returning with nothing outstanding are leftovers from a burst that
  // was in flight across a reset.
  assign push       = avm_readdatavalid && (outstanding_reg != '0);
  assign st_valid   = (fifo_count_reg != '0);
  assign st_data    = fifo_mem[rd_ptr_reg];
  assign pop        = st_valid && st_ready;
  assign take_start = (state_reg == IDLE) && start;

  assign busy = (state_reg != IDLE);
  assign done = (state_reg == FINISH);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) state_next = (num_words == 32'd0) ? FINISH : ISSUE;
      end
      ISSUE: begin
        if (accept && (to_issue_reg == len)) state_next = DRAIN;
      end
      DRAIN: begin
        if (pop && (to_deliver_reg == 32'd1)) state_next = FINISH;
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      addr_reg        <= '0;
      to_issue_reg    <= '0;
      to_deliver_reg  <= '0;
      outstanding_reg <= '0;
      fifo_count_reg  <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
    end else begin
      state_reg <= state_next;
      if (take_start && (num_words != 32'd0)) begin
        addr_reg       <= start_addr;
        to_issue_reg   <= num_words;
        to_deliver_reg <= num_words;
      end else begin
        if (accept) begin
          addr_reg     <= addr_reg + ADDR_W'(len);
          to_issue_reg <= to_issue_reg - len;
        end
        if (pop) to_deliver_reg <= to_deliver_reg - 32'd1;
      end
      outstanding_reg <= outstanding_reg
                         + (accept ? CNT_W'(len) : CNT_W'(0))
                         - (push ? CNT_W'(1) : CNT_W'(0));
      fifo_count_reg  <= fifo_count_reg
                         + (push ? CNT_W'(1) : CNT_W'(0))
                         - (pop ? CNT_W'(1) : CNT_W'(0));
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= avm_readdata;
  end

`ifdef SDRAM_READER_CSUM_EN
  logic [63:0] csum_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           csum_reg <= '0;
    else if (take_start) csum_reg <= '0;
    else if (pop)        csum_reg <= csum_reg + 64'(st_data);
  end

  assign checksum = csum_reg;
`endif

endmodule

// File: tb/tb_sdram_burst_reader.sv
module tb_sdram_burst_reader;

  localparam int ADDR_W     = 29;
  localparam int DATA_W     = 64;
  localparam int BURST_W    = 8;
  localparam int MAX_BURST  = 16;
  localparam int FIFO_DEPTH = 64;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [ADDR_W-1:0]  start_addr;
  logic [31:0]        num_words;
  logic               busy;
  logic               done;
  logic [ADDR_W-1:0]  avm_address;
  logic [BURST_W-1:0] avm_burstcount;
  logic               avm_read;
  logic               avm_waitrequest = 1'b0;
  logic [DATA_W-1:0]  avm_readdata = '0;
  logic               avm_readdatavalid = 1'b0;
  logic [DATA_W-1:0]  st_data;
  logic               st_valid;
  logic               st_ready;
`ifdef SDRAM_READER_CSUM_EN
  logic [63:0]        checksum;
`endif

  always #5 clk = ~clk;

  sdram_burst_reader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W),
    .MAX_BURST(MAX_BURST), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
    .num_words(num_words), .busy(busy), .done(done),
    .avm_address(avm_address), .avm_burstcount(avm_burstcount), .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .st_data(st_data), .st_valid(st_valid), .st_ready(st_ready)
`ifdef SDRAM_READER_CSUM_EN
    , .checksum(checksum)
`endif
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory image of the slave; the checksum test overrides four words.
  bit          csum_mode = 1'b0;
  logic [28:0] csum_base = 29'h500;
  logic [63:0] csum_vals [4] = '{64'd1, 64'd2, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF};

  function automatic logic [63:0] word_at(input logic [28:0] a);
    logic [28:0] off;
    off = a - csum_base;
    if (csum_mode && off < 29'd4) return csum_vals[int'(off)];
    return {a, 6'h2A, ~a};
  endfunction

  typedef struct { logic [28:0] addr; int len; } burst_t;

  burst_t      exp_burst_q[$];
  logic [63:0] exp_q[$];
  logic [28:0] resp_q[$];

  // Slave / bench control
  int stall_n     = 0;
  bit wait_rand   = 1'b0;
  bit rdv_rand    = 1'b0;
  bit inject_stale = 1'b0;

  // Monitor bookkeeping
  int          cyc = 0;
  int          last_pop_cyc = -1;
  int          done_cnt = 0;
  int          burst_cnt = 0;
  int          issued = 0;
  int          popped = 0;
  int          stall_cnt = 0;
  bit          prev_stall = 1'b0;
  bit          prev_done = 1'b0;
  logic [28:0] prev_addr = '0;
  logic [7:0]  prev_bc = '0;
  logic [63:0] model_sum = '0;

  // Observes the cycle mid-way and accounts for what the next edge commits.
  always @(negedge clk) begin
    burst_t      b;
    logic [63:0] e;
    cyc++;
    if (reset) begin
      prev_stall = 1'b0;
      prev_done  = 1'b0;
      stall_cnt  = 0;
    end else begin
      if (prev_stall) begin
        check("hold_read", 64'(avm_read), 64'(1));
        check("hold_addr", 64'(avm_address), 64'(prev_addr));
        check("hold_burstcount", 64'(avm_burstcount), 64'(prev_bc));
      end
      prev_stall = avm_read && avm_waitrequest;
      prev_addr  = avm_address;
      prev_bc    = avm_burstcount;
      if (avm_read && avm_waitrequest) stall_cnt++;
      if (avm_read && !avm_waitrequest) begin
        stall_cnt = 0;
        burst_cnt++;
        issued += int'(avm_burstcount);
        check("burst_expected", 64'(exp_burst_q.size() != 0), 64'(1));
        if (exp_burst_q.size() != 0) begin
          b = exp_burst_q.pop_front();
          check("burst_addr", 64'(avm_address), 64'(b.addr));
          check("burst_len", 64'(avm_burstcount), 64'(b.len));
        end
        for (int i = 0; i < int'(avm_burstcount); i++) resp_q.push_back(avm_address + 29'(i));
      end
      if (st_valid && st_ready) begin
        popped++;
        last_pop_cyc = cyc;
        check("pop_expected", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("st_data", st_data, e);
          model_sum += e;
        end
      end
      check("fifo_credit_bound", 64'((issued - popped) <= FIFO_DEPTH), 64'(1));
      if (done) begin
        done_cnt++;
        if (last_pop_cyc >= 0) check("done_after_last_pop", 64'(cyc), 64'(last_pop_cyc + 1));
      end
      if (prev_done) check("busy_drop_after_done", 64'(busy), 64'(0));
      prev_done = done;
    end
  end

  // Slave response driver.
  always @(posedge clk) begin
    #1;
    if (inject_stale) begin
      avm_readdatavalid = 1'b1;
      avm_readdata      = 64'hDEAD_BEEF_DEAD_BEEF;
    end else if (resp_q.size() != 0 && (!rdv_rand || $urandom_range(0, 9) < 7)) begin
      avm_readdatavalid = 1'b1;
      avm_readdata      = word_at(resp_q.pop_front());
    end else begin
      avm_readdatavalid = 1'b0;
      avm_readdata      = '0;
    end
    avm_waitrequest = wait_rand ? ($urandom_range(0, 2) == 0) : (stall_cnt < stall_n);
  end

  // Reference: the expected word stream and the burst split.
  task automatic load_model(input logic [28:0] a, input int n);
    logic [28:0] ba;
    int rem, l;
    exp_q.delete();
    exp_burst_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(word_at(a + 29'(i)));
    ba  = a;
    rem = n;
    while (rem > 0) begin
      l = (rem < MAX_BURST) ? rem : MAX_BURST;
      exp_burst_q.push_back('{ba, l});
      ba  = ba + 29'(l);
      rem = rem - l;
    end
    done_cnt = 0; burst_cnt = 0; issued = 0; popped = 0;
    last_pop_cyc = -1; model_sum = '0;
  endtask

  task automatic run_xfer(input logic [28:0] a, input int n, input int stall, input bit wrand,
                          input bit rrand, input int ready_low, input bit rdvrand, output int bursts);
    int c;
    load_model(a, n);
    stall_n = stall; wait_rand = wrand; rdv_rand = rdvrand;
    @(posedge clk); #1;
    start = 1'b1; start_addr = a; num_words = 32'(n);
    st_ready = (ready_low == 0);
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_at_n1", 64'(busy), 64'(1));
    check("read_at_n1", 64'(avm_read), 64'(1));
    for (c = 0; c < 5000 && done_cnt == 0; c++) begin
      if (c == 2 && busy) begin
        start = 1'b1; start_addr = 29'($urandom); num_words = 32'd7;
      end else begin
        start = 1'b0;
      end
      st_ready = rrand ? ($urandom_range(0, 3) != 0) : (c >= ready_low);
      if (n >= FIFO_DEPTH && ready_low > 70 && c == ready_low - 1)
        check("credit_fill_while_stalled", 64'(issued), 64'(FIFO_DEPTH));
      @(posedge clk); #1;
    end
    start = 1'b0;
    st_ready = 1'b1;
    check("done_seen", 64'(done_cnt), 64'(1));
    if (done_cnt == 0) begin
      reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
    end
    repeat (3) begin @(posedge clk); #1; end
    check("done_single_pulse", 64'(done_cnt), 64'(1));
    check("idle_after", 64'(busy), 64'(0));
    check("fifo_empty_after", 64'(st_valid), 64'(0));
    check("all_words_delivered", 64'(exp_q.size()), 64'(0));
    check("all_bursts_issued", 64'(exp_burst_q.size()), 64'(0));
`ifdef SDRAM_READER_CSUM_EN
    check("checksum_model", checksum, model_sum);
`endif
    bursts = burst_cnt;
    $display("xfer addr=0x%07h words=%0d bursts=%0d cycles=%0d", a, n, burst_cnt, c);
  endtask

  typedef struct {
    logic [28:0] addr;
    int          n;
    int          stall;
    int          ready_low;
    int          exp_bursts;
  } vec_t;

  initial begin
    vec_t vecs [6];
    int   bursts;
    int   n;
    logic [28:0] a;

    vecs[0] = '{29'h100,       40,  0, 0,   3};
    vecs[1] = '{29'h100,       40,  3, 0,   3};
    vecs[2] = '{29'h200,       200, 0, 500, 13};
    vecs[3] = '{29'h1FFFFFFC,  20,  1, 0,   2};
    vecs[4] = '{29'h55,        16,  0, 0,   1};
    vecs[5] = '{29'h0,         1,   2, 0,   1};

    reset = 1'b1; start = 1'b0; start_addr = '0; num_words = '0; st_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_read", 64'(avm_read), 64'(0));
    check("rst_address", 64'(avm_address), 64'(0));
    check("rst_burstcount", 64'(avm_burstcount), 64'(0));
    check("rst_st_valid", 64'(st_valid), 64'(0));
`ifdef SDRAM_READER_CSUM_EN
    check("rst_checksum", checksum, 64'(0));
`endif
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      run_xfer(vecs[i].addr, vecs[i].n, vecs[i].stall, 1'b0, 1'b0, vecs[i].ready_low, 1'b0, bursts);
      check("table_bursts", 64'(bursts), 64'(vecs[i].exp_bursts));
    end

    // Zero-length transfer: done at N+1, busy only at N+1, no reads.
    load_model(29'h10, 0);
    stall_n = 0; wait_rand = 1'b0; rdv_rand = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; start_addr = 29'h10; num_words = 32'd0;
    @(posedge clk); #1;
    start = 1'b0;
    check("zero_done_n1", 64'(done), 64'(1));
    check("zero_busy_n1", 64'(busy), 64'(1));
    check("zero_no_read", 64'(avm_read), 64'(0));
    @(posedge clk); #1;
    check("zero_busy_n2", 64'(busy), 64'(0));
    check("zero_done_n2", 64'(done), 64'(0));
    check("zero_no_bursts", 64'(burst_cnt), 64'(0));
`ifdef SDRAM_READER_CSUM_EN
    check("zero_checksum", checksum, 64'(0));
`endif
    $display("xfer addr=0x%07h words=0 bursts=%0d", 29'h10, burst_cnt);

    // Reset during the second burst, then a stale readdatavalid.
    load_model(29'h300, 40);
    stall_n = 1; wait_rand = 1'b0; rdv_rand = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; start_addr = 29'h300; num_words = 32'd40; st_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 200 && burst_cnt < 2; c++) begin @(posedge clk); #1; end
    check("second_burst_reached", 64'(burst_cnt >= 2), 64'(1));
    reset = 1'b1;
    #1;
    check("async_rst_busy", 64'(busy), 64'(0));
    check("async_rst_read", 64'(avm_read), 64'(0));
    check("async_rst_address", 64'(avm_address), 64'(0));
    check("async_rst_burstcount", 64'(avm_burstcount), 64'(0));
    check("async_rst_st_valid", 64'(st_valid), 64'(0));
    check("async_rst_done", 64'(done), 64'(0));
    repeat (2) begin @(posedge clk); #1; end
    resp_q.delete();
    load_model(29'h0, 0);
    reset = 1'b0;
    @(negedge clk);
    inject_stale = 1'b1;
    @(posedge clk); #2;
    inject_stale = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("stale_dropped", 64'(st_valid), 64'(0));
    check("stale_idle", 64'(busy), 64'(0));
    $display("reset mid-transfer and stale word handled");
    run_xfer(29'h400, 16, 0, 1'b0, 1'b0, 0, 1'b0, bursts);
    check("post_reset_bursts", 64'(bursts), 64'(1));

`ifdef SDRAM_READER_CSUM_EN
    csum_mode = 1'b1;
    run_xfer(csum_base, 4, 0, 1'b0, 1'b0, 0, 1'b0, bursts);
    check("checksum_five", checksum, 64'd5);
    repeat (4) begin @(posedge clk); #1; end
    check("checksum_held", checksum, 64'd5);
    csum_mode = 1'b0;
`endif

    // Randomized transfers against the reference model.
    for (int i = 0; i < 6; i++) begin
      a = (i == 0) ? 29'h1FFFFFF8 : 29'($urandom);
      n = $urandom_range(1, 90);
      run_xfer(a, n, 0, 1'b1, 1'b1, 0, 1'b1, bursts);
      check("rand_bursts", 64'(bursts), 64'((n + MAX_BURST - 1) / MAX_BURST));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sdram_burst_reader.md
# sdram_burst_reader

Avalon-MM burst read master that fetches a contiguous block of 64-bit words from HPS DDR3 through the `f2h_sdram0` read-only port of `soc_system`, and presents them as a ready/valid stream to FPGA fabric logic. It sits directly upstream of the `hps_0_f2h_sdram0_data_*` / `hps_0_f2h_sdram0_clock_clk` conduit: it drives address, burstcount and read, and consumes readdata and readdatavalid. An internal credit-checked FIFO decouples DDR latency from downstream backpressure.

## Interface
- `ADDR_W`, 29: Avalon word address width (64-bit words).
- `DATA_W`, 64: data width.
- `BURST_W`, 8: burstcount width.
- `MAX_BURST`, 16: maximum words per burst; 1..2^(BURST_W-1).
- `FIFO_DEPTH`, 64: stream FIFO depth; power of two, at least 2*MAX_BURST.

- `clk` in 1: single clock; also drives `hps_0_f2h_sdram0_clock_clk`.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle request; sampled only when idle.
- `start_addr` in ADDR_W: first word address.
- `num_words` in 32: number of words to read.
- `busy` out 1: a transfer is in progress.
- `done` out 1: one-cycle completion pulse.
- `avm_address` out ADDR_W; `avm_burstcount` out BURST_W; `avm_read` out 1.
- `avm_waitrequest` in 1; `avm_readdata` in DATA_W; `avm_readdatavalid` in 1.
- `st_data` out DATA_W; `st_valid` out 1; `st_ready` in 1.
- `checksum` out 64: present only with `SDRAM_READER_CSUM_EN`.

## Operation
- Reset values: `busy`=0, `done`=0, `avm_read`=0, `avm_address`=0, `avm_burstcount`=0, `st_valid`=0, FIFO empty, `checksum`=0. All counters are cleared.
- FSM states are IDLE, ISSUE, DRAIN and FINISH.
- IDLE: on `start` with `num_words`=0, go to FINISH with no reads issued. On `start` with `num_words`≠0, latch the address and `to_issue`=`to_deliver`=`num_words`, then go to ISSUE.
- ISSUE:
  - Burst length: `len` = min(`to_issue`, MAX_BURST).
  - Assert `avm_read` only while fifo_count + outstanding + len ≤ FIFO_DEPTH.
  - While `avm_waitrequest`=1, hold address, burstcount and read stable.
  - On accept (`avm_read` & !`avm_waitrequest`): address += len (wraps mod 2^ADDR_W), `to_issue` -= len, outstanding += len. Deassert read for at least the next cycle only if the credit check fails.
  - When `to_issue` reaches 0, go to DRAIN.
- Read data path:
  - Each `avm_readdatavalid` pushes `avm_readdata` into the FIFO and decrements outstanding.
  - A readdatavalid arriving together with a burst accept yields outstanding += len−1.
  - readdatavalid received while outstanding=0 (stale after reset) is dropped.
- Stream output:
  - `st_valid` = FIFO not empty; `st_data` = FIFO head (show-ahead).
  - A pop on `st_valid` & `st_ready` decrements `to_deliver`.
- DRAIN: when `to_deliver` reaches 0, go to FINISH.
- FINISH: `done`=1 for one cycle, then IDLE.
- `busy`=1 in ISSUE, DRAIN and FINISH.
- The FIFO cannot overflow by construction. The credit check guarantees this even if `st_ready` is held low forever; in that case reads simply stall.

## Timing
- `start` at cycle N: `busy` at N+1; first `avm_read` at N+1 (credits are always free at start).
- A word returned with readdatavalid at cycle M is visible on `st_data` with `st_valid` at M+1.
- When the final word pops at cycle K, `done` pulses at K+1 and `busy` drops at K+2.
- With `num_words`=0: `done` at N+1, `busy` high only at N+1.
- `start` while `busy`=1 is ignored.
- Asynchronous `reset` mid-transfer returns the block to IDLE immediately and discards FIFO contents. Integrators must hold the bridge in reset with the block.

## Configuration
- `SDRAM_READER_CSUM_EN` defined:
  - `checksum` port exists. It holds the sum mod 2^64 of every word popped on the stream.
  - It is cleared when a new transfer is accepted and held stable after `done`.
- Not defined: no `checksum` port and no adder logic. All other behaviour is identical.

## Test plan
- `start_addr`=0x100, `num_words`=40, MAX_BURST=16, `st_ready`=1, zero-wait slave -> bursts (0x100,16), (0x110,16), (0x120,8); 40 words in order; `done` once.
- Same run with `avm_waitrequest` high for 3 cycles on each burst -> address and burstcount stable while stalled; identical data stream.
- `num_words`=200, `st_ready`=0 for 500 cycles, then 1 -> at most 64 words held and never overflow; reads resume as pops free credits; all 200 words delivered.
- `num_words`=0 -> no `avm_read`; `done` at N+1.
- `reset` pulsed during the second burst, then a late readdatavalid arrives -> outputs return to reset values; stale word dropped; a new `start` of 16 words completes correctly.
- Macro defined, `num_words`=4 with slave data 1, 2, 3, 0xFFFF_FFFF_FFFF_FFFF -> `checksum`=5 after `done`.
